// File: rtl/fetch_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_arb_pkg
// Brief    : Shared types and constants for the W/B/I fetch-engine arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } arb_state_t;

   localparam int REQ_W = 0;
   localparam int REQ_B = 1;
   localparam int REQ_I = 2;

   // Wide enough that any truncation to owner-width + 1 is never a real index.
   localparam logic [7:0] OWNER_INVALID = 8'hFF;

   localparam int DEF_OFFSET_WIDTH = 3;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fetch_rr_pick
// Brief    : Combinational round-robin picker starting the scan at rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_rr_pick
   import fetch_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] pick_onehot,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               pick_valid
);

   int               w_sum;
   logic [IDX_W-1:0] w_k;

   always_comb begin
      pick_onehot = '0;
      pick_idx    = '0;
      pick_valid  = 1'b0;
      w_sum       = 0;
      w_k         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = int'(rr_ptr) + i;
         if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
         w_k = IDX_W'(w_sum);
         if (!pick_valid && req[w_k]) begin
            pick_valid = 1'b1;
            pick_idx   = w_k;
         end
      end
      if (pick_valid) pick_onehot = NUM_REQ'(1) << pick_idx;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_wbi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_wbi_arbiter
// Brief    : Round-robin owner of the tile-fetch engine for W/B/I requesters.
//            Optional WAIT watchdog enabled by FETCH_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_wbi_arbiter
   import fetch_arb_pkg::*;
#(
   parameter int NUM_REQ        = 3,
   parameter int OFFSET_WIDTH   = DEF_OFFSET_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*OFFSET_WIDTH-1:0] req_offset,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              done,
   output logic                            start_fetch,
   output logic                            reset_addr_counter,
   output logic [OFFSET_WIDTH-1:0]         Offset_Control,
   input  logic                            fetch_done,
   output logic                            busy
`ifdef FETCH_ARB_TIMEOUT_EN
   ,
   output logic                            timeout_err
`endif
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int OWN_W = IDX_W + 1;

   arb_state_t        r_state;
   logic [IDX_W-1:0]  r_owner;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [OWN_W-1:0]  r_last_owner;
   logic [IDX_W-1:0]  w_next_ptr;

   logic [NUM_REQ-1:0]      w_pick_onehot;
   logic [IDX_W-1:0]        w_pick_idx;
   logic                    w_pick_valid;
   logic [OFFSET_WIDTH-1:0] w_sel_offset;

   fetch_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req         (req),
      .rr_ptr      (r_rr_ptr),
      .pick_onehot (w_pick_onehot),
      .pick_idx    (w_pick_idx),
      .pick_valid  (w_pick_valid)
   );

   always_comb begin
      w_sel_offset = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_pick_idx == IDX_W'(k)) w_sel_offset = req_offset[k*OFFSET_WIDTH +: OFFSET_WIDTH];
      end
   end

   assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

`ifdef FETCH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
   logic [CNT_W-1:0] r_tmo_cnt;
`else
   // Watchdog limit has no consumer when the watchdog is compiled out.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state            <= IDLE;
         r_owner            <= '0;
         r_rr_ptr           <= IDX_W'(REQ_W);
         r_last_owner       <= OWNER_INVALID[OWN_W-1:0];
         gnt                <= '0;
         done               <= '0;
         start_fetch        <= 1'b0;
         reset_addr_counter <= 1'b0;
         Offset_Control     <= '0;
         busy               <= 1'b0;
`ifdef FETCH_ARB_TIMEOUT_EN
         r_tmo_cnt          <= '0;
         timeout_err        <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               done <= '0;
               if (w_pick_valid) begin
                  r_owner            <= w_pick_idx;
                  Offset_Control     <= w_sel_offset;
                  gnt                <= w_pick_onehot;
                  // Same owner as last time: the address counter streams on.
                  reset_addr_counter <= ({1'b0, w_pick_idx} != r_last_owner);
                  busy               <= 1'b1;
                  r_state            <= SETUP;
               end
            end
            SETUP: begin
               reset_addr_counter <= 1'b0;
               start_fetch        <= 1'b1;
               r_state            <= LAUNCH;
            end
            LAUNCH: begin
               start_fetch <= 1'b0;
`ifdef FETCH_ARB_TIMEOUT_EN
               r_tmo_cnt   <= '0;
`endif
               r_state     <= WAIT;
            end
            WAIT: begin
               if (fetch_done) begin
                  done    <= gnt;
                  r_state <= DONE;
               end
`ifdef FETCH_ARB_TIMEOUT_EN
               else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
                  // Abandon the tile; forget the owner so the next grant rewinds.
                  timeout_err  <= 1'b1;
                  done         <= gnt;
                  gnt          <= '0;
                  busy         <= 1'b0;
                  r_last_owner <= OWNER_INVALID[OWN_W-1:0];
                  r_rr_ptr     <= w_next_ptr;
                  r_state      <= IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               done         <= '0;
               gnt          <= '0;
               busy         <= 1'b0;
               r_last_owner <= {1'b0, r_owner};
               r_rr_ptr     <= w_next_ptr;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_wbi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_wbi_arbiter
// Brief    : Directed self-checking bench for fetch_wbi_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_wbi_arbiter;
   import fetch_arb_pkg::*;

   localparam int NR  = 3;
   localparam int OW  = 3;
   localparam int TMO = 64;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NR-1:0]  req;
   logic [NR*OW-1:0] req_offset;
   logic [NR-1:0]  gnt;
   logic [NR-1:0]  done;
   logic           start_fetch;
   logic           reset_addr_counter;
   logic [OW-1:0]  Offset_Control;
   logic           fetch_done;
   logic           busy;
`ifdef FETCH_ARB_TIMEOUT_EN
   logic           timeout_err;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_wbi_arbiter #(
      .NUM_REQ        (NR),
      .OFFSET_WIDTH   (OW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req                (req),
      .req_offset         (req_offset),
      .gnt                (gnt),
      .done               (done),
      .start_fetch        (start_fetch),
      .reset_addr_counter (reset_addr_counter),
      .Offset_Control     (Offset_Control),
      .fetch_done         (fetch_done),
      .busy               (busy)
`ifdef FETCH_ARB_TIMEOUT_EN
      ,
      .timeout_err        (timeout_err)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NR*OW-1:0] offs(input logic [OW-1:0] w, input logic [OW-1:0] b,
                                              input logic [OW-1:0] i);
      logic [NR*OW-1:0] v;
      v = '0;
      v[REQ_W*OW +: OW] = w;
      v[REQ_B*OW +: OW] = b;
      v[REQ_I*OW +: OW] = i;
      return v;
   endfunction

   // Entered at the negedge of an IDLE cycle whose req will be sampled; returns at
   // the negedge of the IDLE cycle after DONE. lat = fetch_done delay after start_fetch.
   task automatic txn(input logic [NR-1:0] exp_gnt, input logic [OW-1:0] exp_off,
                      input logic exp_rac, input int lat, input logic drop, input logic inject);
      @(negedge clk);
      check_val("setup_gnt", gnt, exp_gnt);
      check_val("setup_off", Offset_Control, exp_off);
      check_val("setup_rac", reset_addr_counter, exp_rac);
      check_val("setup_start", start_fetch, 0);
      check_val("setup_busy", busy, 1);
      if (drop) begin
         req        = '0;
         req_offset = '1;
      end
      fetch_done = inject;
      @(negedge clk);
      fetch_done = inject;
      check_val("launch_start", start_fetch, 1);
      check_val("launch_rac", reset_addr_counter, 0);
      check_val("launch_done", done, 0);
      @(negedge clk);
      fetch_done = 1'b0;
      check_val("wait_start", start_fetch, 0);
      check_val("wait_done", done, 0);
      check_val("wait_gnt", gnt, exp_gnt);
      repeat (lat-1) @(negedge clk);
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
      check_val("done_pulse", done, exp_gnt);
      check_val("done_gnt", gnt, exp_gnt);
      check_val("done_off", Offset_Control, exp_off);
      @(negedge clk);
      check_val("idle_done", done, 0);
      check_val("idle_gnt", gnt, 0);
      check_val("idle_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      req_offset = '0;
      fetch_done = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_gnt", gnt, 0);
      check_val("rst_done", done, 0);
      check_val("rst_start", start_fetch, 0);
      check_val("rst_rac", reset_addr_counter, 0);
      check_val("rst_off", Offset_Control, 0);
      check_val("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // First W tile: rewind forced, 34-cycle engine.
      req        = 3'b001;
      req_offset = offs(3'd2, 3'd0, 3'd0);
      txn(3'b001, 3'd2, 1'b1, 34, 1'b0, 1'b0);
      // W again: no rewind; req drops and offsets change mid-transaction.
      txn(3'b001, 3'd2, 1'b0, 5, 1'b1, 1'b0);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // All three held: W, B, I, W with a rewind on each switch.
      req        = 3'b111;
      req_offset = offs(3'd0, 3'd1, 3'd4);
      txn(3'b001, 3'd0, 1'b1, 3, 1'b0, 1'b0);
      txn(3'b010, 3'd1, 1'b1, 3, 1'b0, 1'b0);
      txn(3'b100, 3'd4, 1'b1, 3, 1'b0, 1'b0);
      txn(3'b001, 3'd0, 1'b1, 3, 1'b1, 1'b0);

      // Stray fetch_done in IDLE, then in SETUP and LAUNCH.
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
      check_val("stray_busy", busy, 0);
      check_val("stray_done", done, 0);
      check_val("stray_gnt", gnt, 0);
      req        = 3'b100;
      req_offset = offs(3'd0, 3'd0, 3'd5);
      txn(3'b100, 3'd5, 1'b1, 4, 1'b0, 1'b1);

      // I repeats (no rewind), then reset lands in WAIT.
      @(negedge clk);
      check_val("rep_gnt", gnt, 3'b100);
      check_val("rep_rac", reset_addr_counter, 0);
      @(negedge clk);
      @(negedge clk);
      check_val("rep_wait_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("arst_gnt", gnt, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_start", start_fetch, 0);
      check_val("arst_off", Offset_Control, 0);
      check_val("arst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      txn(3'b100, 3'd5, 1'b1, 3, 1'b1, 1'b0);

`ifdef FETCH_ARB_TIMEOUT_EN
      begin
         int  k;
         logic seen;
         req        = 3'b001;
         req_offset = offs(3'd3, 3'd0, 3'd0);
         @(negedge clk);
         check_val("tmo_setup_gnt", gnt, 3'b001);
         @(negedge clk);
         check_val("tmo_launch", start_fetch, 1);
         req  = '0;
         k    = 0;
         seen = 1'b0;
         while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (done != 0) seen = 1'b1;
         end
         // Watchdog trips in the TMO-th WAIT cycle; done follows one cycle later.
         check_val("tmo_latency", k, TMO + 1);
         check_val("tmo_done", done, 3'b001);
         check_val("tmo_err", timeout_err, 1);
         @(negedge clk);
         check_val("tmo_idle_done", done, 0);
         check_val("tmo_idle_busy", busy, 0);
         check_val("tmo_err_sticky", timeout_err, 1);
         req = 3'b001;
         txn(3'b001, 3'd3, 1'b1, 3, 1'b1, 1'b0);
         check_val("tmo_err_final", timeout_err, 1);
      end
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
